ps2_keyboard: RTL and testbench

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

---
 rtl/ps2_keyboard_pkg.sv | 20 ++
 rtl/ps2_keyboard_fifo.sv | 48 ++++
 rtl/ps2_keyboard.sv | 105 ++++++++++
 tb/tb_ps2_keyboard.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ps2_keyboard_pkg.sv
// Shared constants, FSM encodings and frame check for the PS/2 keyboard receiver.
// The FIFO depth and timeout defaults here are what the CPU-side blocks also see.
package ps2_keyboard_pkg;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int FRAME_BITS     = 11;
  localparam int TIMEOUT_DEF    = 50000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_e;

  // Captured bits: [7:0] data, [8] parity, [9] stop. Stop must be 1 and parity odd.
  function automatic logic frame_valid(input logic [9:0] f);
    return f[9] & (^f[8:0]);
  endfunction

endpackage

// File: rtl/ps2_keyboard_fifo.sv
// Show-ahead scan-code FIFO; occupancy is tracked by a count register so the
// pointers can simply wrap modulo the power-of-two depth.
module kbd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr];

  // Storage is cleared on reset so the head reads 8'h00 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: line synchronizers, frame FSM with idle timeout,
// sticky overflow flag and a scan-code FIFO read through the mmio pop strobe.
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       kbd_read_enable,
  output logic [7:0] kbd_data,
  output logic       kbd_ready,
  output logic       kbd_overflow
);
  localparam int         TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 2);

  logic [2:0]      r_clk_sync;
  logic [2:0]      r_data_sync;
  rx_state_e       r_state;
  logic [3:0]      r_bit_cnt;
  logic [9:0]      r_shift;
  logic [TO_W-1:0] r_timeout;
  logic            r_overflow;

  logic w_fall, w_data, w_valid, w_pop, w_push, w_ovf_set;
  logic w_empty, w_full;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync  <= 3'b111;
      r_data_sync <= 3'b111;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
      r_data_sync <= {r_data_sync[1:0], ps2_data};
    end
  end

  assign w_fall = !r_clk_sync[1] && r_clk_sync[2];
  assign w_data = r_data_sync[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_timeout <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          r_timeout <= '0;
          if (w_fall && !w_data) r_state <= ST_RECV;
        end
        ST_RECV: begin
          if (w_fall) begin
            r_shift   <= {w_data, r_shift[9:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_timeout <= '0;
            if (r_bit_cnt == LAST_BIT) r_state <= ST_CHECK;
          end else if (r_timeout == TO_LAST) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
          end else begin
            r_timeout <= r_timeout + 1'b1;
          end
        end
        ST_CHECK: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // A pop in the CHECK cycle frees the slot the new frame needs.
  assign w_valid   = (r_state == ST_CHECK) && frame_valid(r_shift);
  assign w_pop     = kbd_read_enable && !w_empty;
  assign w_push    = w_valid && (!w_full || w_pop);
  assign w_ovf_set = w_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst)            r_overflow <= 1'b0;
    else if (w_ovf_set) r_overflow <= 1'b1;
    else if (w_pop)     r_overflow <= 1'b0;
  end

  kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_shift[7:0]),
    .dout  (kbd_data),
    .empty (w_empty),
    .full  (w_full)
  );

  assign kbd_ready    = !w_empty;
  assign kbd_overflow = r_overflow;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: frames are bit-banged on the PS/2 lines and
// the FIFO outputs are compared against hand-computed scan codes.
module tb_ps2_keyboard;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       kbd_read_enable = 1'b0;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_keyboard #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .ps2_clk         (ps2_clk),
    .ps2_data        (ps2_data),
    .kbd_read_enable (kbd_read_enable),
    .kbd_data        (kbd_data),
    .kbd_ready       (kbd_ready),
    .kbd_overflow    (kbd_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Sends start, 8 data bits, parity, stop. Reports kbd_ready 3 and 4 cycles
  // after the stop falling edge and optionally pops during the CHECK cycle.
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                            input logic pop_in_check, output logic rdy3, output logic rdy4);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ par_flip);
    ps2_data = stop;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    rdy3 = kbd_ready;
    if (pop_in_check) kbd_read_enable = 1'b1;
    @(negedge clk);
    kbd_read_enable = 1'b0;
    rdy4 = kbd_ready;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    logic r3, r4;
    send_frame(d, 1'b0, 1'b1, 1'b0, r3, r4);
  endtask

  task automatic read_chk(input string tag, input logic [7:0] exp);
    chk(tag, {24'h0, kbd_data}, {24'h0, exp});
    kbd_read_enable = 1'b1;
    @(negedge clk);
    kbd_read_enable = 1'b0;
  endtask

  initial begin
    logic r3, r4;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'h0, kbd_ready}, 32'h0);
    chk("reset_ovf", {31'h0, kbd_overflow}, 32'h0);
    chk("reset_data", {24'h0, kbd_data}, 32'h0);

    // Single frame 0x1C, latency and pop.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, r3, r4);
    chk("lat_ready_n3", {31'h0, r3}, 32'h0);
    chk("lat_ready_n4", {31'h0, r4}, 32'h1);
    read_chk("single_1C", 8'h1C);
    chk("single_ready_after_pop", {31'h0, kbd_ready}, 32'h0);

    // Two frames in order.
    send(8'hF0);
    send(8'h1C);
    read_chk("seq_F0", 8'hF0);
    read_chk("seq_1C", 8'h1C);
    chk("seq_ovf", {31'h0, kbd_overflow}, 32'h0);
    chk("seq_ready", {31'h0, kbd_ready}, 32'h0);

    // Bad parity and bad stop bit are discarded.
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, r3, r4);
    chk("badpar_ready", {31'h0, kbd_ready}, 32'h0);
    chk("badpar_count", 32'(dut.u_fifo.r_count), 32'h0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, r3, r4);
    chk("badstop_ready", {31'h0, kbd_ready}, 32'h0);
    chk("badstop_count", 32'(dut.u_fifo.r_count), 32'h0);

    // Overflow on the ninth frame.
    for (int i = 1; i <= 9; i++) send(8'(i));
    chk("ovf_set", {31'h0, kbd_overflow}, 32'h1);
    chk("ovf_count", 32'(dut.u_fifo.r_count), 32'h8);
    for (int i = 1; i <= 8; i++) begin
      read_chk($sformatf("ovf_read_%0d", i), 8'(i));
      if (i == 1) chk("ovf_clear", {31'h0, kbd_overflow}, 32'h0);
    end
    chk("ovf_drained", {31'h0, kbd_ready}, 32'h0);

    // Full FIFO with a pop during CHECK accepts the new frame.
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i));
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, r3, r4);
    chk("fullpop_ovf", {31'h0, kbd_overflow}, 32'h0);
    chk("fullpop_count", 32'(dut.u_fifo.r_count), 32'h8);
    for (int i = 1; i < 8; i++) read_chk($sformatf("fullpop_read_%0d", i), 8'h11 + 8'(i));
    read_chk("fullpop_last_55", 8'h55);
    chk("fullpop_empty", {31'h0, kbd_ready}, 32'h0);

    // Partial frame abandoned by timeout.
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    repeat (TO + 50) @(negedge clk);
    send(8'h2A);
    chk("timeout_count", 32'(dut.u_fifo.r_count), 32'h1);
    read_chk("timeout_2A", 8'h2A);
    chk("timeout_empty", {31'h0, kbd_ready}, 32'h0);

    // Partial frame abandoned by reset.
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h2A);
    chk("rstmid_count", 32'(dut.u_fifo.r_count), 32'h1);
    read_chk("rstmid_2A", 8'h2A);
    chk("rstmid_empty", {31'h0, kbd_ready}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
